// File: rtl/reg_wb_arbiter_pkg.sv
// Shared write-back definitions: data width, register count, priority encodings.
`ifndef REG_LEN
`define REG_LEN 32
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif
`ifndef WB_PRI_LSU
`define WB_PRI_LSU 0
`endif
`ifndef WB_PRI_ALU
`define WB_PRI_ALU 1
`endif

package reg_wb_arbiter_pkg;

  // Which requester wins when both are valid in the same cycle.
  typedef enum logic {
    PRI_LSU = 1'(`WB_PRI_LSU),
    PRI_ALU = 1'(`WB_PRI_ALU)
  } wb_pri_e;

  localparam int WB_REG_LEN = `REG_LEN;
  localparam int WB_REG_NUM = `REG_NUM;

endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Busy scoreboard: one bit per register with a write in flight.
module wb_scoreboard #(
  parameter int ADDR_LEN = 5,
  parameter int REG_NUM  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  logic [ADDR_LEN-1:0] iss_rd,
  output logic                iss_ready,
  input  logic                clr_en,
  input  logic [ADDR_LEN-1:0] clr_rd,
  input  logic [ADDR_LEN-1:0] rs1,
  input  logic [ADDR_LEN-1:0] rs2,
  output logic                rs1_busy,
  output logic                rs2_busy
);

  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               iss_set;

  // Lookups read the registered vector only; a clear in this cycle is seen next cycle.
  assign iss_ready = !((iss_rd != '0) && busy_q[iss_rd]);
  assign iss_set   = iss_valid && iss_ready && (iss_rd != '0);
  assign rs1_busy  = busy_q[rs1];
  assign rs2_busy  = busy_q[rs2];

  // Next busy vector: clear first so a same-cycle reservation of that register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && (clr_rd != '0)) busy_d[clr_rd] = 1'b0;
    if (iss_set)                  busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter for the register file write port (ALU vs LSU) plus busy scoreboard.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int ADDR_LEN = 5,
  parameter int REG_LEN  = WB_REG_LEN,
  parameter int REG_NUM  = WB_REG_NUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [ADDR_LEN-1:0] alu_rd,
  input  logic [REG_LEN-1:0]  alu_d,
  output logic                alu_ready,
  input  logic                lsu_valid,
  input  logic [ADDR_LEN-1:0] lsu_rd,
  input  logic [REG_LEN-1:0]  lsu_d,
  output logic                lsu_ready,
  input  logic                iss_valid,
  input  logic [ADDR_LEN-1:0] iss_rd,
  output logic                iss_ready,
  input  logic [ADDR_LEN-1:0] rs1,
  input  logic [ADDR_LEN-1:0] rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [ADDR_LEN-1:0] rd,
  output logic [REG_LEN-1:0]  rd_d,
  output logic                reg_wr
);

  wb_pri_e             pri_q, pri_d;
  logic                gnt_alu, gnt_lsu, xfer;
  logic [ADDR_LEN-1:0] sel_rd;
  logic [REG_LEN-1:0]  sel_d;
  logic [ADDR_LEN-1:0] wr_addr_q, wr_addr_d;
  logic [REG_LEN-1:0]  wr_data_q, wr_data_d;
  logic                reg_wr_q, reg_wr_d;

  // Grant: a lone requester always wins; under contention the priority flop decides.
  always_comb begin
    gnt_alu = alu_valid && (!lsu_valid || (pri_q == PRI_ALU));
    gnt_lsu = lsu_valid && (!alu_valid || (pri_q == PRI_LSU));
    xfer    = gnt_alu || gnt_lsu;
    sel_rd  = gnt_alu ? alu_rd : lsu_rd;
    sel_d   = gnt_alu ? alu_d  : lsu_d;
  end

  assign alu_ready = gnt_alu;
  assign lsu_ready = gnt_lsu;

  // Next write-port state; x0 writes update address/data but never pulse the enable.
  always_comb begin
    pri_d     = pri_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    reg_wr_d  = 1'b0;
    if (xfer) begin
      pri_d     = gnt_alu ? PRI_LSU : PRI_ALU;
      wr_addr_d = sel_rd;
      wr_data_d = sel_d;
      reg_wr_d  = (sel_rd != '0);
    end
  end

  // Priority flop and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_q     <= PRI_LSU;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      reg_wr_q  <= 1'b0;
    end else begin
      pri_q     <= pri_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      reg_wr_q  <= reg_wr_d;
    end
  end

  assign rd     = wr_addr_q;
  assign rd_d   = wr_data_q;
  assign reg_wr = reg_wr_q;

  wb_scoreboard #(
    .ADDR_LEN (ADDR_LEN),
    .REG_NUM  (REG_NUM)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .clr_en    (xfer),
    .clr_rd    (sel_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench: expected writes go into a queue, a negedge monitor pops and checks them.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, iss_valid;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1, rs2;
  logic [31:0] alu_d, lsu_d;
  logic        alu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy, reg_wr;
  logic [4:0]  rd;
  logic [31:0] rd_d;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  vecs = 0;
  int  errs = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_d(alu_d), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_d(lsu_d), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd(rd), .rd_d(rd_d), .reg_wr(reg_wr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wr_t w;
    w.rd = r;
    w.d  = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every write-enable pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_wr", {27'd0, rd}, 32'hFFFFFFFF);
      else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_rd", {27'd0, rd}, {27'd0, w.rd});
        chk("wr_data", rd_d, w.d);
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu_valid = 0; lsu_valid = 0; iss_valid = 0;
    alu_rd = 0; lsu_rd = 0; iss_rd = 5; rs1 = 0; rs2 = 0;
    alu_d = 0; lsu_d = 0;
    #2;
    chk("rst_reg_wr", {31'd0, reg_wr}, 0);
    chk("rst_rd", {27'd0, rd}, 0);
    chk("rst_rd_d", rd_d, 0);
    chk("rst_iss_ready", {31'd0, iss_ready}, 1);
    step; step;
    rst = 1'b0;
    iss_rd = 0;

    // Contention from reset: LSU, ALU, LSU, ALU, then the leftover LSU request.
    lsu_valid = 1; lsu_rd = 10; lsu_d = 32'h1000_0000;
    alu_valid = 1; alu_rd = 20; alu_d = 32'h2000_0000;
    #1;
    chk("cont1_lsu", {31'd0, lsu_ready}, 1);
    chk("cont1_alu", {31'd0, alu_ready}, 0);
    push(10, 32'h1000_0000);
    step;
    lsu_rd = 11; lsu_d = 32'h1000_0001;
    #1;
    chk("cont2_alu", {31'd0, alu_ready}, 1);
    chk("cont2_lsu", {31'd0, lsu_ready}, 0);
    chk("cont2_wr", {31'd0, reg_wr}, 1);
    push(20, 32'h2000_0000);
    step;
    alu_rd = 21; alu_d = 32'h2000_0001;
    #1;
    chk("cont3_lsu", {31'd0, lsu_ready}, 1);
    chk("cont3_alu", {31'd0, alu_ready}, 0);
    chk("cont3_wr", {31'd0, reg_wr}, 1);
    push(11, 32'h1000_0001);
    step;
    lsu_rd = 12; lsu_d = 32'h1000_0002;
    #1;
    chk("cont4_alu", {31'd0, alu_ready}, 1);
    chk("cont4_lsu", {31'd0, lsu_ready}, 0);
    chk("cont4_wr", {31'd0, reg_wr}, 1);
    push(21, 32'h2000_0001);
    step;
    alu_valid = 0;
    #1;
    chk("cont5_lsu", {31'd0, lsu_ready}, 1);
    chk("cont5_wr", {31'd0, reg_wr}, 1);
    push(12, 32'h1000_0002);
    step;
    lsu_valid = 0;

    // Single ALU write to a reserved x7.
    iss_valid = 1; iss_rd = 7;
    #1;
    chk("iss7_ready", {31'd0, iss_ready}, 1);
    step;
    iss_valid = 0; rs1 = 7;
    alu_valid = 1; alu_rd = 7; alu_d = 32'hDEADBEEF;
    #1;
    chk("x7_busy", {31'd0, rs1_busy}, 1);
    chk("x7_alu_ready", {31'd0, alu_ready}, 1);
    push(7, 32'hDEADBEEF);
    step;
    alu_valid = 0;
    #1;
    chk("x7_cleared", {31'd0, rs1_busy}, 0);
    chk("x7_wr", {31'd0, reg_wr}, 1);

    // WAW stall on x3 until the LSU write to x3 is accepted.
    iss_valid = 1; iss_rd = 3;
    #1;
    chk("iss3_first", {31'd0, iss_ready}, 1);
    step;
    lsu_valid = 1; lsu_rd = 3; lsu_d = 32'h0000_0033;
    #1;
    chk("iss3_stall", {31'd0, iss_ready}, 0);
    chk("x3_lsu_ready", {31'd0, lsu_ready}, 1);
    push(3, 32'h0000_0033);
    step;
    lsu_rd = 3; lsu_d = 32'h0000_0044;
    #1;
    chk("iss3_release", {31'd0, iss_ready}, 1);
    push(3, 32'h0000_0044);
    step;
    iss_valid = 0; lsu_valid = 0; rs2 = 3;
    #1;
    chk("x3_rebusy_cleared", {31'd0, rs2_busy}, 1);
    step;
    #1;
    chk("x3_idle_busy", {31'd0, rs2_busy}, 1);
    lsu_valid = 1; lsu_rd = 3; lsu_d = 32'h0000_0055;
    push(3, 32'h0000_0055);
    step;
    lsu_valid = 0;
    #1;
    chk("x3_final_clear", {31'd0, rs2_busy}, 0);

    // x0: accepted, no enable, address/data still move; reservation of x0 ignored.
    alu_valid = 1; alu_rd = 0; alu_d = 32'h0000_1234;
    iss_valid = 1; iss_rd = 0;
    #1;
    chk("x0_alu_ready", {31'd0, alu_ready}, 1);
    chk("x0_iss_ready", {31'd0, iss_ready}, 1);
    step;
    alu_valid = 0; iss_valid = 0; rs1 = 0; rs2 = 0;
    #1;
    chk("x0_reg_wr", {31'd0, reg_wr}, 0);
    chk("x0_rd", {27'd0, rd}, 0);
    chk("x0_rd_d", rd_d, 32'h0000_1234);
    chk("x0_rs1_busy", {31'd0, rs1_busy}, 0);
    chk("x0_rs2_busy", {31'd0, rs2_busy}, 0);

    // Reservation and write of x9 in the same cycle: the reservation survives.
    alu_valid = 1; alu_rd = 9; alu_d = 32'h0000_0099;
    iss_valid = 1; iss_rd = 9; rs1 = 9;
    #1;
    chk("x9_iss_ready", {31'd0, iss_ready}, 1);
    chk("x9_alu_ready", {31'd0, alu_ready}, 1);
    push(9, 32'h0000_0099);
    step;
    alu_valid = 0; iss_valid = 0;
    #1;
    chk("x9_busy_after", {31'd0, rs1_busy}, 1);
    alu_valid = 1; alu_d = 32'h0000_009A;
    push(9, 32'h0000_009A);
    step;
    alu_valid = 0;
    #1;
    chk("x9_cleared", {31'd0, rs1_busy}, 0);

    // Mid-cycle reset with x5 busy and a write in flight; priority left at ALU.
    iss_valid = 1; iss_rd = 5; rs1 = 5;
    lsu_valid = 1; lsu_rd = 12; lsu_d = 32'h0000_ABCD;
    #1;
    chk("mr_lsu_ready", {31'd0, lsu_ready}, 1);
    step;
    iss_valid = 0; lsu_valid = 0;
    #1;
    chk("mr_pre_wr", {31'd0, reg_wr}, 1);
    chk("mr_pre_busy", {31'd0, rs1_busy}, 1);
    rst = 1'b1;
    #1;
    chk("mr_reg_wr", {31'd0, reg_wr}, 0);
    chk("mr_rd", {27'd0, rd}, 0);
    chk("mr_rd_d", rd_d, 0);
    chk("mr_busy5", {31'd0, rs1_busy}, 0);
    alu_valid = 1; lsu_valid = 1; alu_rd = 1; lsu_rd = 2;
    #1;
    chk("mr_pri_lsu", {31'd0, lsu_ready}, 1);
    chk("mr_pri_alu", {31'd0, alu_ready}, 0);
    step;
    alu_valid = 0; lsu_valid = 0;
    step;
    rst = 1'b0;
    step; step;

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
